cart_accumulator: RTL

CART_ACCUMULATOR -- requirements
Module: cart_accumulator

---
 rtl/cart_pkg.sv | 11 +
 rtl/cart_mult.sv | 74 +++++++
 rtl/cart_accumulator.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared FSM state type and default sizing for the cart accumulator.
package cart_pkg;

    localparam int PRICE_W_DEF   = 14;
    localparam int TOTAL_W_DEF   = 17;
    localparam int TOTAL_MAX_DEF = 99999;
    localparam int QTY_MAX_DEF   = 99;

    typedef enum logic [1:0] {IDLE, ADD, MUL, ERR} cartState_t;

endpackage

// File: rtl/cart_mult.sv
// Iterative LSB-first shift-add multiplier; the first step is taken on the start edge
// so the product is ready (done high) after exactly QTY_W edges.
module cart_mult
    import cart_pkg::*;
#(
    parameter int TOTAL_W   = TOTAL_W_DEF,
    parameter int TOTAL_MAX = TOTAL_MAX_DEF,
    parameter int QTY_W     = $clog2(QTY_MAX_DEF + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TOTAL_W-1:0] multiplicand,
    input  logic [QTY_W-1:0]   multiplier,
    output logic               done,
    output logic [TOTAL_W-1:0] product,
    output logic               ovf
);

    localparam int CNT_W = $clog2(QTY_W + 1);
    localparam logic [TOTAL_W:0] TOTAL_LIM = (TOTAL_W + 1)'(TOTAL_MAX);

    logic [TOTAL_W-1:0] acc, srcAcc, nextAcc;
    logic [TOTAL_W:0]   mcand, srcMcand, nextMcand, sum;
    logic [QTY_W-1:0]   mplier, srcMplier, nextMplier;
    logic               ovfReg, srcOvf, nextOvf, running;
    logic [CNT_W-1:0]   cnt;

    // Once the shifted multiplicand exceeds the limit it is pinned just above it, so any
    // later set bit reports overflow instead of wrapping.
    always_comb begin
        srcAcc     = start ? '0 : acc;
        srcMcand   = start ? {1'b0, multiplicand} : mcand;
        srcMplier  = start ? multiplier : mplier;
        srcOvf     = start ? 1'b0 : ovfReg;
        sum        = {1'b0, srcAcc} + srcMcand;
        nextAcc    = srcAcc;
        nextOvf    = srcOvf;
        if (srcMplier[0]) begin
            if (sum > TOTAL_LIM) begin
                nextOvf = 1'b1;
            end else begin
                nextAcc = sum[TOTAL_W-1:0];
            end
        end
        nextMcand  = (srcMcand > TOTAL_LIM) ? TOTAL_LIM + 1'b1 : srcMcand << 1;
        nextMplier = srcMplier >> 1;
    end

    assign done    = running && (cnt == CNT_W'(QTY_W));
    assign product = acc;
    assign ovf     = ovfReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            ovfReg  <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (start || (running && !done)) begin
            acc     <= nextAcc;
            mcand   <= nextMcand;
            mplier  <= nextMplier;
            ovfReg  <= nextOvf;
            running <= 1'b1;
            cnt     <= start ? CNT_W'(1) : cnt + 1'b1;
        end else if (done) begin
            running <= 1'b0;
        end
    end

endmodule

// File: rtl/cart_accumulator.sv
// Shopping-cart total accumulator with quantity multiply and sticky overflow.
// Define UNDO_EN to build the undo history LIFO; otherwise the undo port is ignored.
module cart_accumulator
    import cart_pkg::*;
#(
    parameter int PRICE_W   = PRICE_W_DEF,
    parameter int TOTAL_W   = TOTAL_W_DEF,
    parameter int TOTAL_MAX = TOTAL_MAX_DEF,
    parameter int QTY_MAX   = QTY_MAX_DEF,
    parameter int DEPTH     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PRICE_W-1:0] inNumbers,
    input  logic               store,
    input  logic               update,
    input  logic               show,
    input  logic               undo,
    input  logic               errIn,
    output logic               busy,
    output logic [TOTAL_W-1:0] outNumbers,
    output logic               outValid,
    output logic               overflow,
    output logic               errOut
);

    localparam int QTY_W = $clog2(QTY_MAX + 1);
    localparam logic [TOTAL_W:0]   TOTAL_LIM = (TOTAL_W + 1)'(TOTAL_MAX);
    localparam logic [PRICE_W-1:0] QTY_LIM   = PRICE_W'(QTY_MAX);

    cartState_t         state;
    logic [TOTAL_W-1:0] total, pending, lineReg, mulProduct, undoTop;
    logic [TOTAL_W:0]   addSum;
    logic               mulStart, mulDone, mulOvf, doPop;

    assign addSum   = {1'b0, total} + {1'b0, pending};
    assign mulStart = (state == IDLE) && !show && update && (inNumbers <= QTY_LIM);
    assign errOut   = errIn | overflow;

    cart_mult #(
        .TOTAL_W   (TOTAL_W),
        .TOTAL_MAX (TOTAL_MAX),
        .QTY_W     (QTY_W)
    ) mult (
        .clk          (clk),
        .reset        (reset),
        .start        (mulStart),
        .multiplicand (pending),
        .multiplier   (inNumbers[QTY_W-1:0]),
        .done         (mulDone),
        .product      (mulProduct),
        .ovf          (mulOvf)
    );

`ifdef UNDO_EN
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int UCNT_W = $clog2(DEPTH + 1);

    logic [TOTAL_W-1:0] undoMem [DEPTH];
    logic [PTR_W-1:0]   wrPtr, topPtr;
    logic [UCNT_W-1:0]  undoCount;
    logic               doPush;

    assign topPtr  = (wrPtr == '0) ? PTR_W'(DEPTH - 1) : wrPtr - 1'b1;
    assign undoTop = undoMem[topPtr];
    assign doPush  = (state == ADD) && !errIn && (addSum <= TOTAL_LIM) && (pending != '0);
    assign doPop   = (state == IDLE) && !show && !update && !store && undo && (undoCount != '0);

    always_ff @(posedge clk) begin
        if (!reset && doPush) begin
            undoMem[wrPtr] <= pending;
        end
    end

    // Circular history: a push onto a full LIFO overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            undoCount <= '0;
        end else if (doPush) begin
            wrPtr     <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            undoCount <= (undoCount == UCNT_W'(DEPTH)) ? undoCount : undoCount + 1'b1;
        end else if (doPop) begin
            wrPtr     <= topPtr;
            undoCount <= undoCount - 1'b1;
        end
    end
`else
    logic unusedUndo;
    assign unusedUndo = undo;
    assign undoTop    = '0;
    assign doPop      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            total      <= '0;
            pending    <= '0;
            lineReg    <= '0;
            outNumbers <= '0;
            outValid   <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (show) begin
                        lineReg <= '0;
                        state   <= ADD;
                        busy    <= 1'b1;
                    end else if (update) begin
                        if (inNumbers > QTY_LIM) begin
                            state    <= ERR;
                            overflow <= 1'b1;
                        end else begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end
                    end else if (store) begin
                        lineReg <= TOTAL_W'(inNumbers);
                        state   <= ADD;
                        busy    <= 1'b1;
                    end else if (doPop) begin
                        total      <= total - undoTop;
                        outNumbers <= total - undoTop;
                        outValid   <= 1'b1;
                    end
                end
                // An external error drops the commit silently rather than flagging overflow.
                ADD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!errIn) begin
                        if (addSum > TOTAL_LIM) begin
                            state    <= ERR;
                            overflow <= 1'b1;
                        end else begin
                            total      <= addSum[TOTAL_W-1:0];
                            outNumbers <= addSum[TOTAL_W-1:0];
                            pending    <= lineReg;
                            outValid   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mulDone) begin
                        busy <= 1'b0;
                        if (mulOvf) begin
                            state    <= ERR;
                            overflow <= 1'b1;
                        end else begin
                            pending <= mulProduct;
                            state   <= IDLE;
                        end
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
